// File: rtl/serial_pkg.sv
// Shared types for the bit-serial adder/subtractor datapath.
// Holds the control-state encoding and the supported operand-width ceiling.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 64;

endpackage : serial_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell, purely combinational (zero latency).
// No flow control: outputs follow inputs in the same cycle.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/serial_addsub_n.sv
// Bit-serial two's-complement add/sub, LSB first; result valid WIDTH edges after start.
// start is honoured only in IDLE/DONE; a start during SHIFT is dropped, not queued.
module serial_addsub_n
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_addsub_n: WIDTH out of range");
    end

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_step;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        accept    = start && ((state == IDLE) || (state == DONE));
        last_step = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
        sum_next  = {fa_s, sum_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_step) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Subtraction is in1 + ~in2 + 1; the +1 enters as the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            out    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr  <= in1;
            b_sr  <= sub ? ~in2 : in2;
            carry <= sub;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            sum_sr <= sum_next;
            carry  <= fa_co;
            if (last_step) begin
                out  <= sum_next;
                cout <= fa_co;
                // carry still holds the carry into the MSB at this step
                ovf  <= carry ^ fa_co;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule : serial_addsub_n

// File: tb/tb_serial_addsub_n.sv
// Self-checking bench for serial_addsub_n at WIDTH 8, 2 and 32.
// Directed corner vectors plus random add/sub against an integer reference model.
module tb_serial_addsub_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        sub;
    logic [63:0] opa;
    logic [63:0] opb;
    logic        st0, st1, st2;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  out8;
    logic        busy2, done2, cout2, ovf2;
    logic [1:0]  out2;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] out32;

    always #5 clk = ~clk;

    serial_addsub_n #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(st0), .sub(sub),
        .in1(opa[7:0]), .in2(opb[7:0]),
        .busy(busy8), .done(done8), .out(out8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub_n #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .start(st1), .sub(sub),
        .in1(opa[1:0]), .in2(opb[1:0]),
        .busy(busy2), .done(done2), .out(out2), .cout(cout2), .ovf(ovf2)
    );

    serial_addsub_n #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .start(st2), .sub(sub),
        .in1(opa[31:0]), .in2(opb[31:0]),
        .busy(busy32), .done(done32), .out(out32), .cout(cout32), .ovf(ovf32)
    );

    int          sel;
    logic        cur_busy, cur_done, cur_cout, cur_ovf;
    logic [63:0] cur_out;

    always_comb begin
        cur_busy = 1'b0;
        cur_done = 1'b0;
        cur_cout = 1'b0;
        cur_ovf  = 1'b0;
        cur_out  = '0;
        case (sel)
            0: begin
                cur_busy = busy8; cur_done = done8; cur_cout = cout8;
                cur_ovf = ovf8; cur_out = 64'(out8);
            end
            1: begin
                cur_busy = busy2; cur_done = done2; cur_cout = cout2;
                cur_ovf = ovf2; cur_out = 64'(out2);
            end
            default: begin
                cur_busy = busy32; cur_done = done32; cur_cout = cout32;
                cur_ovf = ovf32; cur_out = 64'(out32);
            end
        endcase
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input int s);
        return (s == 0) ? 8 : (s == 1) ? 2 : 32;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input bit s, input logic [63:0] x,
                                  input logic [63:0] y, output logic [63:0] o,
                                  output bit c, output bit v);
        longint m  = longint'(1) << w;
        longint ux = longint'(x) & (m - 1);
        longint uy = longint'(y) & (m - 1);
        longint sx = (ux >= m / 2) ? ux - m : ux;
        longint sy = (uy >= m / 2) ? uy - m : uy;
        longint r  = s ? ux - uy : ux + uy;
        longint sr = s ? sx - sy : sx + sy;
        o = 64'(r & (m - 1));
        c = s ? (ux >= uy) : (r >= m);
        v = (sr < -(m / 2)) || (sr >= m / 2);
    endfunction

    task automatic drive_start(input bit v);
        case (sel)
            0:       st0 = v;
            1:       st1 = v;
            default: st2 = v;
        endcase
    endtask

    task automatic issue(input bit s, input logic [63:0] x, input logic [63:0] y);
        sub = s;
        opa = x;
        opb = y;
        drive_start(1'b1);
    endtask

    // Called at a negedge right after issue(); returns at the negedge where done is seen.
    task automatic wait_done(input string tag, input int glitch_at);
        int w     = wid(sel);
        int nbusy = 0;
        int lat   = 0;
        bit both  = 1'b0;
        for (int i = 1; i <= 2 * w + 8 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) drive_start(1'b0);
            if (glitch_at != 0 && i == glitch_at) begin
                sub = ~sub;
                opa = {$urandom, $urandom};
                opb = {$urandom, $urandom};
                drive_start(1'b1);
            end
            if (glitch_at != 0 && i == glitch_at + 1) drive_start(1'b0);
            if (cur_busy && cur_done) both = 1'b1;
            if (cur_busy) nbusy++;
            if (cur_done) lat = i;
        end
        check({tag, "_latency"}, 64'(lat), 64'(w + 1));
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'(w));
        check({tag, "_busy_done_overlap"}, 64'(both), 64'(0));
    endtask

    task automatic check_res(input string tag, input logic [63:0] o, input bit c, input bit v);
        check({tag, "_out"}, cur_out, o);
        check({tag, "_cout"}, 64'(cur_cout), 64'(c));
        check({tag, "_ovf"}, 64'(cur_ovf), 64'(v));
    endtask

    logic [7:0] ta [5] = '{8'h02, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] tb [5] = '{8'h08, 8'h01, 8'h01, 8'h07, 8'h01};
    bit         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] to [5] = '{8'h0A, 8'h00, 8'h80, 8'hFE, 8'h7F};
    bit         tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit         tv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [63:0] eo;
        bit          ec, ev;
        bit          seen;
        logic [63:0] held;

        sel = 0;
        rst = 1'b1;
        sub = 1'b0;
        opa = '0;
        opb = '0;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(cur_busy), 64'(0));
        check("reset_done", 64'(cur_done), 64'(0));
        check("reset_out", cur_out, 64'(0));
        check("reset_cout", 64'(cur_cout), 64'(0));
        check("reset_ovf", 64'(cur_ovf), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // directed corner vectors at WIDTH=8
        for (int k = 0; k < 5; k++) begin
            issue(ts[k], 64'(ta[k]), 64'(tb[k]));
            wait_done("dir", 0);
            check_res("dir", 64'(to[k]), tc[k], tv[k]);
            held = cur_out;
            @(negedge clk);
            check("dir_done_drops", 64'(cur_done), 64'(0));
            check("dir_out_held", cur_out, held);
        end

        // start pulsed mid-operation must be ignored
        issue(1'b0, 64'h21, 64'h13);
        wait_done("glitch", 4);
        check_res("glitch", 64'h34, 1'b0, 1'b0);
        @(negedge clk);
        check("glitch_no_second_op", 64'(cur_busy), 64'(0));

        // back-to-back: start held in the done cycle
        issue(1'b1, 64'h10, 64'h20);
        wait_done("b2b_first", 0);
        check_res("b2b_first", 64'hF0, 1'b0, 1'b0);
        issue(1'b0, 64'h40, 64'h40);
        wait_done("b2b_second", 0);
        check_res("b2b_second", 64'h80, 1'b0, 1'b1);

        // reset while bit 4 would be processed
        @(negedge clk);
        issue(1'b0, 64'h55, 64'h33);
        @(negedge clk);
        drive_start(1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 64'(cur_busy), 64'(0));
        check("rst_mid_out", cur_out, 64'(0));
        check("rst_mid_ovf", 64'(cur_ovf), 64'(0));
        seen = cur_done;
        repeat (12) begin
            @(negedge clk);
            if (cur_done) seen = 1'b1;
        end
        check("rst_mid_no_done", 64'(seen), 64'(0));
        issue(1'b0, 64'h55, 64'h33);
        wait_done("after_rst", 0);
        check_res("after_rst", 64'h88, 1'b0, 1'b1);

        // random vectors on every width against the reference model
        for (int s = 0; s < 3; s++) begin
            sel = s;
            @(negedge clk);
            for (int n = 0; n < 30; n++) begin
                bit          m;
                logic [63:0] x, y;
                m = 1'($urandom_range(0, 1));
                x = {$urandom, $urandom};
                y = {$urandom, $urandom};
                if (n == 0) begin
                    x = '1;
                    y = '1;
                end
                model(wid(s), m, x, y, eo, ec, ev);
                issue(m, x, y);
                wait_done("rnd", 0);
                check_res($sformatf("rnd_w%0d", wid(s)), eo, ec, ev);
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule : tb_serial_addsub_n
